// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if
//   Bundles the fetch-queue handshakes: the instruction-memory request and
//   response ports, the core-side instruction port and the branch redirect.
//   master : the fetch queue (drives requests and instructions).
//   slave  : the environment (memory + core).
//   Signals:
//     mem_req_valid/addr/ready   fetch request, word-aligned byte address
//     mem_resp_valid/data        in-order response, no backpressure
//     inst_valid/inst/inst_pc    head instruction and its PC
//     inst_ready                 core consumes the head
//     redirect_valid/pc          taken branch, restart fetch at redirect_pc
`timescale 1ns/1ps
interface inst_fetch_queue_if;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
      output mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch front-end: issues sequential word fetches to a
//   variable-latency memory, tags each in-flight request with its PC, and
//   buffers returned words in an in-order {pc, inst} FIFO for the core.
//   A redirect flushes the FIFO, restarts fetch at the new PC and arranges
//   for responses still in flight to be discarded.
//   Parameters:
//     DEPTH     queue entries, also the cap on queued + in-flight (pow2, >=2)
//     RESET_PC  first fetch address after reset
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-low reset (0 = reset, 1 = run)
//     bus   inst_fetch_queue_if.master (memory, core and redirect handshakes)
//   Build option:
//     FETCH_QUEUE_BYPASS_EN  when defined, a response arriving at an empty,
//                            drop-free queue is presented to the core in the
//                            same cycle and skips the FIFO if consumed.
`timescale 1ns/1ps
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                   clk,
   input logic                   rst,
   inst_fetch_queue_if.master    bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [31:0]   fetch_pc;

   // Instruction FIFO
   logic [31:0]   q_inst [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic [AW-1:0] q_head;
   logic [AW-1:0] q_tail;
   logic [CW-1:0] count;

   // PC tags of requests accepted but not yet answered; depth equals inflight
   logic [31:0]   tag_pc [DEPTH];
   logic [AW-1:0] tag_head;
   logic [AW-1:0] tag_tail;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop_cnt;

   logic [CW:0]   occupancy;
   logic          req_fire;
   logic          resp_drop;
   logic          resp_keep;
   logic          head_valid;
   logic          bypass_take;
   logic          push;
   logic          pop;
   logic          unused_pc_bits;

   assign unused_pc_bits = ^bus.redirect_pc[1:0];

   assign occupancy  = {1'b0, count} + {1'b0, inflight};
   assign head_valid = rst && (count != '0);
   assign resp_drop  = bus.mem_resp_valid && (drop_cnt != '0);
   assign resp_keep  = bus.mem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;

   // Request port
   assign bus.mem_req_valid = rst && !bus.redirect_valid && (occupancy < DEPTH_W);
   assign bus.mem_req_addr  = rst ? fetch_pc : RESET_PC;
   assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass_hit;

   // resp_keep already excludes redirect cycles and pending drops
   assign bypass_hit  = rst && (count == '0) && resp_keep;
   assign bypass_take = bypass_hit && bus.inst_ready;

   assign bus.inst_valid = head_valid || bypass_hit;
   assign bus.inst       = head_valid ? q_inst[q_head]
                         : (bypass_hit ? bus.mem_resp_data : '0);
   assign bus.inst_pc    = head_valid ? q_pc[q_head]
                         : (bypass_hit ? tag_pc[tag_head] : '0);
`else
   assign bypass_take = 1'b0;

   assign bus.inst_valid = head_valid;
   assign bus.inst       = head_valid ? q_inst[q_head] : '0;
   assign bus.inst_pc    = head_valid ? q_pc[q_head]   : '0;
`endif

   assign push = resp_keep && !bypass_take;
   assign pop  = head_valid && bus.inst_ready && !bus.redirect_valid;

   // Control state
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         q_head   <= '0;
         q_tail   <= '0;
         count    <= '0;
         tag_head <= '0;
         tag_tail <= '0;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         // The tag FIFO tracks every outstanding request, including those
         // whose responses will be dropped, so it is never flushed.
         if (req_fire)
            tag_tail <= tag_tail + PTR_ONE;
         if (bus.mem_resp_valid)
            tag_head <= tag_head + PTR_ONE;

         case ({req_fire, bus.mem_resp_valid})
            2'b10:   inflight <= inflight + CNT_ONE;
            2'b01:   inflight <= inflight - CNT_ONE;
            default: ;
         endcase

         if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            q_head   <= '0;
            q_tail   <= '0;
            count    <= '0;
            // A response landing in the redirect cycle is already discarded
            drop_cnt <= inflight - CW'(bus.mem_resp_valid);
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            if (push)
               q_tail <= q_tail + PTR_ONE;
            if (pop)
               q_head <= q_head + PTR_ONE;
            case ({push, pop})
               2'b10:   count <= count + CNT_ONE;
               2'b01:   count <= count - CNT_ONE;
               default: ;
            endcase
            if (resp_drop)
               drop_cnt <= drop_cnt - CNT_ONE;
         end
      end
   end

   // Storage arrays carry no reset; validity lives in the pointers/counters
   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[q_tail] <= bus.mem_resp_data;
         q_pc[q_tail]   <= tag_pc[tag_head];
      end
      if (req_fire)
         tag_pc[tag_tail] <= fetch_pc;
   end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front-end sitting directly upstream of the single-cycle RISC-V core's decode/execute path. It generates sequential fetch addresses, issues them to a variable-latency instruction memory over a valid/ready request port, and buffers returned words with their PCs in an in-order FIFO. The core consumes instructions through a valid/ready port. On a taken branch the core sends a redirect, which flushes the queue and discards stale in-flight responses.

## Interface

Parameters:
- `DEPTH`, 4: queue entries; also caps total in-flight requests. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset, 1 = run), same as the core's `start` net.
- `mem_req_valid` out 1: fetch request valid.
- `mem_req_addr` out 32: fetch byte address, word aligned.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: one response word valid. Responses return in request order. There is no backpressure; the block always accepts a response.
- `mem_resp_data` in 32: instruction word.
- `inst_valid` out 1: head entry is valid.
- `inst` out 32: head instruction.
- `inst_pc` out 32: PC of the head instruction.
- `inst_ready` in 1: core consumes the head entry.
- `redirect_valid` in 1: taken branch; restart fetch.
- `redirect_pc` in 32: new fetch PC. Bits [1:0] are ignored and treated as 0.

## Operation

- State:
  - `fetch_pc`
  - FIFO of {pc, inst} with `count` from 0 to DEPTH
  - `inflight` from 0 to DEPTH: requests accepted but not yet responded
  - `drop_cnt` ≤ `inflight`: responses to discard
  - `pc_fifo`: tags in-flight requests with their PC
- Issue:
  - `mem_req_valid` = rst & ~redirect_valid & (count + inflight < DEPTH).
  - `mem_req_addr` = `fetch_pc`.
  - Request fire (valid & ready): `fetch_pc` += 4 (wraps modulo 2^32), `inflight` += 1.
- Response:
  - If `drop_cnt` > 0: word discarded, `drop_cnt` −= 1.
  - Otherwise the word is pushed with its tagged PC.
  - `inflight` −= 1 in both cases.
- Dequeue:
  - `inst_valid` = (count ≠ 0).
  - `inst` and `inst_pc` show the head entry.
  - Fire (valid & ready) pops the head.
- Redirect cycle:
  - FIFO is cleared: `count` ← 0, and any simultaneous pop or push is ignored.
  - `fetch_pc` ← {redirect_pc[31:2], 2'b00}.
  - `drop_cnt` ← `inflight` − (response this cycle ? 1 : 0).
  - No request is issued that cycle.
- Invariant: count + inflight ≤ DEPTH, so a push never meets a full FIFO. Push and pop in the same cycle leave `count` unchanged.

## Timing

- Reset:
  - In any cycle with rst=0, all state is initialised at the edge: `fetch_pc`=RESET_PC, `count`=`inflight`=`drop_cnt`=0.
  - Outputs while rst=0: `mem_req_valid`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `mem_req_addr`=RESET_PC.
  - Reset mid-operation abandons all in-flight requests. The memory model must be reset too.
- First request is presented the cycle after rst rises to 1.
- Without bypass: a response pushed at edge N is visible on `inst_valid` from cycle N+1. Minimum fetch-to-issue latency is 1 + memory latency + 1 cycles.
- Sustained throughput is one instruction per cycle when memory latency + 1 < DEPTH.
- After a redirect at edge N:
  - `inst_valid`=0 in cycle N+1 (bypass cannot fire either, since `drop_cnt` absorbs old responses).
  - The first request to `redirect_pc` is presented in cycle N+1.
- `inst` and `inst_pc` are held stable while `inst_valid`=1 and `inst_ready`=0.

## Configuration

- `FETCH_QUEUE_BYPASS_EN` defined:
  - Applies when `count`=0, `drop_cnt`=0, `mem_resp_valid`=1 and `redirect_valid`=0.
  - In that case `inst_valid`=1 and `inst`/`inst_pc` come combinationally from the response in the same cycle.
  - If `inst_ready`=1 the word is consumed and not written. Otherwise it is pushed.
- Not defined: every response goes through the FIFO, and the output is a pure register read (1-cycle extra latency, no comb path from `mem_resp_*` to `inst_*`).

## Test plan

- Reset then stream:
  - Stimulus: rst low 3 cycles, then high; memory with 1-cycle latency returning word = addr ^ 32'hA5A5_0000; `inst_ready`=1.
  - Required: requests at 0x0, 0x4, 0x8, …; `inst_pc`/`inst` pairs match; one instruction per cycle in steady state.
- Backpressure full:
  - Stimulus: `inst_ready`=0 for 10 cycles, DEPTH=4.
  - Required: exactly 4 requests issued, `mem_req_valid` then 0, count=4, head `inst_pc`=0x0 held stable; on release, 0x0–0xC are delivered in order.
- Redirect with in-flight requests:
  - Stimulus: memory latency 3; `redirect_valid` with `redirect_pc`=0x100 while 3 requests are outstanding.
  - Required: the 3 stale responses are dropped; the next delivered `inst_pc`=0x100, then 0x104.
- Redirect coincident with a response and `inst_ready`:
  - Required: the response is dropped, the head is not double-popped, `inst_valid`=0 next cycle, and `redirect_pc`=0x203 is fetched as 0x200.
- Memory stall:
  - Stimulus: `mem_req_ready`=0 for 5 cycles.
  - Required: `mem_req_addr` is held, `fetch_pc` does not advance, and no instruction is lost.
- Bypass (macro defined):
  - Stimulus: empty queue, response arrives with `inst_ready`=1.
  - Required: `inst_valid`=1 in the same cycle and count stays 0. Without the macro, the instruction appears one cycle later.
